// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one polynomial RAM (one write port, one read port) among N_CH client
// engines. Ownership is steered directly by the controller (mode=0, owner=sel)
// or rotated among requesting engines (mode=1, round-robin with burst hold).
// Read strobes are tagged with the owner index and the tag travels alongside
// the RAM read latency, so the read-valid lands on the channel that issued the
// read even when ownership has moved on. Writes from non-owners are dropped
// and latched into a sticky per-channel error flag.
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   mode, sel      0 = fixed owner sel, 1 = round-robin over ch_req
//   ch_req         per-channel ownership request (round-robin mode)
//   ch_wen/waddr/wdata  per-channel write port (packed, channel i at slice i)
//   ch_ren/raddr   per-channel read port (packed)
//   ch_gnt         one-hot current owner, zero when unowned
//   ch_rvalid      one-hot read-return valid, RD_LAT cycles after the strobe
//   ch_rdata       RAM read data, broadcast to all channels
//   wr_block_err   sticky: channel wrote while not owner
//   ram_*          RAM-side write/read address and data
module ram_port_arbiter #(
    parameter int N_CH   = 4,
    parameter int DW     = 96,
    parameter int AW     = 8,
    parameter int RD_LAT = 1,
    parameter int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [CW-1:0]     sel,
    input  logic [N_CH-1:0]   ch_req,
    input  logic [N_CH-1:0]   ch_wen,
    input  logic [N_CH*AW-1:0] ch_waddr,
    input  logic [N_CH*DW-1:0] ch_wdata,
    input  logic [N_CH-1:0]   ch_ren,
    input  logic [N_CH*AW-1:0] ch_raddr,
    output logic [N_CH-1:0]   ch_gnt,
    output logic [N_CH-1:0]   ch_rvalid,
    output logic [DW-1:0]     ch_rdata,
    output logic [N_CH-1:0]   wr_block_err,
    output logic              ram_wen,
    output logic [AW-1:0]     ram_waddr,
    output logic [DW-1:0]     ram_wdata,
    output logic [AW-1:0]     ram_raddr,
    input  logic [DW-1:0]     ram_rdata
);

    function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] idx);
        logic [N_CH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [CW-1:0] gidx;
    logic          gvalid;
    logic [CW-1:0] last;

    // Unpacked views of the packed per-channel buses
    logic [AW-1:0] waddr_a [N_CH];
    logic [DW-1:0] wdata_a [N_CH];
    logic [AW-1:0] raddr_a [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            waddr_a[i] = ch_waddr[i*AW +: AW];
            wdata_a[i] = ch_wdata[i*DW +: DW];
            raddr_a[i] = ch_raddr[i*AW +: AW];
        end
    end

    // Round-robin candidate: first requester searching upward from last+1,
    // wrapping, so the most recent winner has lowest priority.
    logic          rr_found;
    logic [CW-1:0] rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last;
        for (int k = 1; k <= N_CH; k++) begin
            if (!rr_found && ch_req[CW'((int'(last) + k) % N_CH)]) begin
                rr_found = 1'b1;
                rr_idx   = CW'((int'(last) + k) % N_CH);
            end
        end
    end

    // Grant register: fixed select, burst hold, rotate, or release
    always_ff @(posedge clk) begin
        if (rst) begin
            gidx   <= '0;
            gvalid <= 1'b0;
            last   <= CW'(N_CH - 1);
        end else if (!mode) begin
            gidx   <= sel;
            gvalid <= 1'b1;
        end else if (gvalid && ch_req[gidx]) begin
            gidx   <= gidx;
        end else if (rr_found) begin
            gidx   <= rr_idx;
            gvalid <= 1'b1;
            last   <= rr_idx;
        end else begin
            gvalid <= 1'b0;
        end
    end

    assign ch_gnt = gvalid ? onehot(gidx) : '0;

    // RAM drive straight from the registered owner; idle port drives zeros
    always_comb begin
        ram_wen   = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        if (gvalid) begin
            ram_wen   = ch_wen[gidx];
            ram_waddr = waddr_a[gidx];
            ram_wdata = wdata_a[gidx];
            ram_raddr = raddr_a[gidx];
        end
    end

    // Any write strobe from a channel that is not the current owner is latched
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_block_err <= '0;
        end else begin
            wr_block_err <= wr_block_err | (ch_wen & ~ch_gnt);
        end
    end

    // Read-tag pipeline, stage p0 aligned with the RAM address cycle
    logic          vld_p [RD_LAT];
    logic [CW-1:0] tag_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) vld_p[s] <= 1'b0;
        end else begin
            vld_p[0] <= gvalid & ch_ren[gidx];
            for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= gidx;
        for (int s = 1; s < RD_LAT; s++) tag_p[s] <= tag_p[s-1];
    end

    // Return stage: tag emerges together with the RAM data
    assign ch_rvalid = vld_p[RD_LAT-1] ? onehot(tag_p[RD_LAT-1]) : '0;
    assign ch_rdata  = ram_rdata;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised arbiter between N client engines and the single shared polynomial RAM (96-bit words, 256 deep). It replaces the combinational select muxes in the Kyber top level. The controller can steer ownership directly (fixed mode), or the arbiter can rotate ownership among requesting engines (round-robin mode). Read returns carry a channel tag, so each client sees its own read data valid after the RAM latency, even when ownership changes mid-stream. Writes from non-owners are blocked and flagged.

## Interface
- N_CH, 4, number of client channels (2..8)
- DW, 96, RAM data width
- AW, 8, RAM address width
- RD_LAT, 1, RAM read latency in cycles (1..3)
- CW, $clog2(N_CH), channel index width (derived)

- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  CW  owner index in fixed mode
- ch_req  in  N_CH  per-channel ownership request (round-robin mode)
- ch_wen  in  N_CH  per-channel write enable
- ch_waddr  in  N_CH*AW  packed write addresses; channel i at [i*AW +: AW]
- ch_wdata  in  N_CH*DW  packed write data
- ch_ren  in  N_CH  per-channel read strobe
- ch_raddr  in  N_CH*AW  packed read addresses
- ch_gnt  out  N_CH  one-hot current owner; all zero when no owner
- ch_rvalid  out  N_CH  one-hot read-return valid
- ch_rdata  out  DW  read data, broadcast to all channels
- wr_block_err  out  N_CH  sticky flag: a non-owner asserted ch_wen
- ram_wen  out  1  to RAM
- ram_waddr  out  AW  to RAM
- ram_wdata  out  DW  to RAM
- ram_raddr  out  AW  to RAM
- ram_rdata  in  DW  from RAM

## Operation
- State: `gidx` (CW bits), `gvalid`, `last` (CW bits), tag pipeline of RD_LAT stages each {v, idx}, and `wr_block_err`.
- **Fixed mode** (mode=0), each cycle: `gidx <= sel`, `gvalid <= 1`. `ch_req` is ignored.
- **Round-robin mode** (mode=1):
  - Hold: if `gvalid` and `ch_req[gidx]` is high, the grant stays unchanged. This locks ownership for bursts.
  - Rotate: otherwise, the grant goes to the first channel with `req=1`, searching upward from `last+1` with wrap (N_CH-1 → 0). Set `gidx` to it, `gvalid <= 1`, `last <= gidx`.
  - No requesters: `gvalid <= 0`. `last` is kept.
- **Mode change** takes effect on the next grant update. Switching 1→0 loads `sel`. Switching 0→1 re-arbitrates from `last`.
- **RAM drive**, combinational from the registered grant:
  - `ram_wen = gvalid & ch_wen[gidx]`.
  - `ram_waddr`, `ram_wdata`, and `ram_raddr` come from slice `gidx`.
  - When `gvalid=0`, these outputs are 0.
- **Read tagging**:
  - Stage 0 captures `{gvalid & ch_ren[gidx], gidx}`.
  - After RD_LAT stages, `ch_rvalid` is the one-hot of idx when v=1.
  - `ch_rdata = ram_rdata`, passed through unregistered.
  - Reads from non-owners are ignored silently.
- **Blocked writes**: `ch_wen[i]=1` while i is not the owner sets `wr_block_err[i]`. The write is not issued. The flag clears only on `rst`.
- **`ch_gnt`**: one-hot of `gidx` when `gvalid`, otherwise all zero.

## Timing
- Reset values:
  - `gidx=0`, `gvalid=0`, `last=N_CH-1` (so channel 0 wins first).
  - All tag stages v=0; `wr_block_err=0`; `ch_gnt=0`; `ch_rvalid=0`.
  - `ram_wen=0`; `ram_waddr`, `ram_wdata`, `ram_raddr` = 0.
- Grant latency: a request or `sel` sampled at edge k is visible on `ch_gnt` after edge k. Clients start RAM accesses in the cycle after they see their grant.
- Write path: zero added latency. `ram_*` follows the owner's inputs in the same cycle.
- Read return: the read strobe at cycle k gives `ch_rvalid` at cycle k+RD_LAT. This holds even if the grant moves at k+1.
- Back-to-back: a new owner may read in its first grant cycle. Returns interleave correctly by tag; there are no bubbles.
- Reset mid-operation: in-flight tags are discarded and no `ch_rvalid` fires. Grant returns to idle on the next cycle.
- Simultaneous release and request by the owner: ch_req low for one cycle releases the grant. The owner competes again from the rotated priority.

## Test plan
- **Fixed mode**: sel=2; ch2 writes addr 0x10 data 0xABC → `ram_wen=1`, `ram_waddr=0x10` in the same cycle. `wr_block_err=0`.
- **Round-robin fairness**: all 4 `ch_req` pulse for 1 cycle each round → `ch_gnt` sequence 0001, 0010, 0100, 1000, 0001.
- **Burst lock**: ch1 holds req 10 cycles while ch3 requests → `ch_gnt=0010` for 10 cycles, then `1000`.
- **Blocked write**: owner ch0; ch3 asserts wen addr 0x20 → `ram_wen` follows ch0 only. `wr_block_err=1000` and stays set until rst.
- **Tagged reads** (RD_LAT=2): ch0 reads at cycle 5, grant moves to ch1 which reads at cycle 6 → `ch_rvalid=0001` at 7, `0010` at 8, each with the matching RAM data.
- **Reset mid-read**: rst at cycle k+1 after a read at k → no `ch_rvalid` at any cycle. All outputs are at reset values the cycle after rst.
